// File: rtl/poly_mult_pkg.sv
// Shared types and index helper for the streaming polynomial multiplier.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package poly_mult_pkg;

  typedef enum logic [1:0] {
    LOAD_U = 2'd0,
    ACCUM  = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  // idx  : (k - j) mod n
  // wrap : set when (idx + j) >= n, i.e. the product term crossed x^n
  typedef struct packed {
    logic        wrap;
    logic [31:0] idx;
  } idx_res_t;

  // k and j are both < n. The term lands past x^n exactly when k < j.
  function automatic idx_res_t idx_sub(input int unsigned k,
                                       input int unsigned j,
                                       input int unsigned n);
    idx_res_t r;
    r.wrap = (k < j);
    r.idx  = r.wrap ? (k + n - j) : (k - j);
    return r;
  endfunction

endpackage

// File: rtl/poly_mac_lane.sv
// One z coefficient accumulator: acc += / -= p * ext(u), truncated to QW bits.
// Latency: result of a beat is visible in o_acc the cycle after i_en.
// Backpressure: none; the owner gates i_en/i_clr with its own handshakes.
// Ports: clk, a_rst (async, active-high), i_en (accumulate this cycle),
//        i_clr (zero the accumulator, wins over i_en), i_sub (subtract),
//        i_p (QW-bit coefficient), i_u (UW-bit small coefficient), o_acc.
module poly_mac_lane
  import poly_mult_pkg::*;
#(
  parameter int QW       = 64,
  parameter int UW       = 2,
  parameter int U_SIGNED = 1
) (
  input  logic          clk,
  input  logic          a_rst,
  input  logic          i_en,
  input  logic          i_clr,
  input  logic          i_sub,
  input  logic [QW-1:0] i_p,
  input  logic [UW-1:0] i_u,
  output logic [QW-1:0] o_acc
);

  logic [QW-1:0] r_acc;
  logic [QW-1:0] w_u_ext;
  logic [QW-1:0] w_prod;

  // Small coefficient widened to QW bits so that a negative u wraps mod 2^QW.
  always_comb begin
    if (U_SIGNED != 0) begin
      w_u_ext = {{(QW-UW){i_u[UW-1]}}, i_u};
    end else begin
      w_u_ext = {{(QW-UW){1'b0}}, i_u};
    end
  end

  assign w_prod = i_p * w_u_ext;

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= i_sub ? (r_acc - w_prod) : (r_acc + w_prod);
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/poly_mult_stream.sv
// Streaming z = p*u mod (x^N +/- 1) mod 2^QW: load N u beats, accumulate N p beats, drain N z beats.
// Latency: first z valid the cycle after p beat N-1 is accepted; minimum frame 3N cycles.
// Backpressure: u/p ready only in their own phase; z held stable while z_vld && !z_rdy.
// Ports: clk, a_rst (async, active-high); cfg_negacyclic (1: mod x^N+1, 0: mod x^N-1);
//        u_vld/u_rdy/u/u_last and p_vld/p_rdy/p/p_last input streams, index 0 first;
//        z_vld/z_rdy/z/z_last output stream; err (sticky framing error).
module poly_mult_stream
  import poly_mult_pkg::*;
#(
  parameter int N        = 16,
  parameter int QW       = 64,
  parameter int UW       = 2,
  parameter int U_SIGNED = 1,
  parameter int CW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          a_rst,
  input  logic          cfg_negacyclic,
  input  logic          u_vld,
  output logic          u_rdy,
  input  logic [UW-1:0] u,
  input  logic          u_last,
  input  logic          p_vld,
  output logic          p_rdy,
  input  logic [QW-1:0] p,
  input  logic          p_last,
  output logic          z_vld,
  input  logic          z_rdy,
  output logic [QW-1:0] z,
  output logic          z_last,
  output logic          err
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [UW-1:0] r_ubuf [N];
  logic          r_neg_q;
  logic          r_err;

  logic          w_u_hs;
  logic          w_p_hs;
  logic          w_z_hs;
  logic          w_cnt_last;
  logic          w_frame_done;
  logic          w_in_beat;
  logic          w_in_last;
  logic [QW-1:0] w_acc [N];

  assign w_cnt_last   = (r_cnt == LAST);
  assign w_u_hs       = u_vld & u_rdy;
  assign w_p_hs       = p_vld & p_rdy;
  assign w_z_hs       = z_vld & z_rdy;
  assign w_frame_done = w_z_hs & w_cnt_last;

  // FSM state register
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      r_state <= LOAD_U;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and stream outputs. u_rdy is gated by a_rst because the
  // reset state is LOAD_U, yet no input may be accepted while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    u_rdy       = 1'b0;
    p_rdy       = 1'b0;
    z_vld       = 1'b0;
    z_last      = 1'b0;
    z           = '0;
    case (r_state)
      LOAD_U: begin
        u_rdy = ~a_rst;
        if (u_vld && w_cnt_last) begin
          w_state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        p_rdy = 1'b1;
        if (p_vld && w_cnt_last) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        z_vld  = 1'b1;
        z      = w_acc[r_cnt];
        z_last = w_cnt_last;
        if (z_rdy && w_cnt_last) begin
          w_state_nxt = LOAD_U;
        end
      end
      default: begin
        w_state_nxt = LOAD_U;
      end
    endcase
  end

  // One shared beat counter: u index, then p index (j), then z index.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      r_cnt <= '0;
    end else if (w_u_hs || w_p_hs || w_z_hs) begin
      r_cnt <= w_cnt_last ? '0 : (r_cnt + 1'b1);
    end
  end

  // u buffer and reduction mode; mode is frozen at the first u beat.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      for (int i = 0; i < N; i++) begin
        r_ubuf[i] <= '0;
      end
      r_neg_q <= 1'b1;
    end else if (w_u_hs) begin
      r_ubuf[r_cnt] <= u;
      if (r_cnt == '0) begin
        r_neg_q <= cfg_negacyclic;
      end
    end
  end

  // Frames are defined by beat count; a last flag that disagrees with the
  // count only raises the sticky error and never cuts the frame short.
  assign w_in_beat = w_u_hs | w_p_hs;
  assign w_in_last = w_u_hs ? u_last : p_last;

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      r_err <= 1'b0;
    end else if (w_in_beat && (w_in_last != w_cnt_last)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;

  // Lane k takes p_j * u_i with i = (k - j) mod N, negated when the term
  // wraps past x^N in negacyclic mode.
  for (genvar g = 0; g < N; g++) begin : g_lane
    idx_res_t      w_res;
    logic [CW-1:0] w_i;
    logic          w_unused_idx_hi;

    always_comb begin
      w_res = idx_sub(g, 32'(r_cnt), N);
    end

    assign w_i             = w_res.idx[CW-1:0];
    assign w_unused_idx_hi = ^w_res.idx[31:CW];

    poly_mac_lane #(
      .QW       (QW),
      .UW       (UW),
      .U_SIGNED (U_SIGNED)
    ) u_lane (
      .clk   (clk),
      .a_rst (a_rst),
      .i_en  (w_p_hs),
      .i_clr (w_frame_done),
      .i_sub (r_neg_q & w_res.wrap),
      .i_p   (p),
      .i_u   (r_ubuf[w_i]),
      .o_acc (w_acc[g])
    );
  end

endmodule
